// File: rtl/ddr_probe_controller_pkg.sv
// ddr_probe_pkg: shared read-FSM state type and channel-select width helper.
// No ports; imported by rotary_step_gen and ddr_probe_controller.
package ddr_probe_pkg;

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int cw_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ddr_probe_controller_rotary_step_gen.sv
// rotary_step_gen: turns left/right rotary pulses into a step event, direction and step size.
// Ports: clk, rst       - clock, synchronous active-high reset
//        i_left/i_right - one-cycle step pulses
//        i_chan         - resolved active channel
//        o_event        - exactly one of left/right this cycle
//        o_up           - step direction (1 = up)
//        o_step         - 1, or ACCEL_STEP when the previous step was recent, same direction, same channel
module rotary_step_gen import ddr_probe_pkg::*; #(
    parameter int CHANNELS     = 4,
    parameter int ADDR_WIDTH   = 24,
    parameter int ACCEL_WINDOW = 1_000_000,
    parameter int ACCEL_STEP   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_left,
    input  logic                        i_right,
    input  logic [cw_of(CHANNELS)-1:0]  i_chan,
    output logic                        o_event,
    output logic                        o_up,
    output logic [ADDR_WIDTH:0]         o_step
);

    localparam int TW = (ACCEL_WINDOW > 0) ? $clog2(ACCEL_WINDOW + 1) : 1;

    logic [TW-1:0]              r_cnt;
    logic                       r_have;
    logic                       r_dir;
    logic [cw_of(CHANNELS)-1:0] r_chan;
    logic                       w_accel;

    assign o_event = i_left ^ i_right;
    assign o_up    = i_right;
    // r_cnt holds (cycles since last step - 1), saturating at ACCEL_WINDOW
    assign w_accel = r_have && (r_dir == i_right) && (r_chan == i_chan) && (r_cnt < TW'(ACCEL_WINDOW));
    assign o_step  = w_accel ? (ADDR_WIDTH+1)'(ACCEL_STEP) : (ADDR_WIDTH+1)'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_have <= 1'b0;
            r_dir  <= 1'b0;
            r_chan <= '0;
        end else if (o_event) begin
            r_cnt  <= '0;
            r_have <= 1'b1;
            r_dir  <= i_right;
            r_chan <= i_chan;
        end else begin
            if (r_cnt < TW'(ACCEL_WINDOW)) r_cnt <= r_cnt + TW'(1);
            if (i_chan != r_chan) r_have <= 1'b0;
        end
    end

endmodule

// File: rtl/ddr_probe_controller.sv
// ddr_probe_controller: multi-channel rotary-stepped DDR probe with req/ack reads and per-channel capture.
// Ports: clk, rst            - clock, synchronous active-high reset
//        left/right/down     - rotary step pulses and read request pulse
//        chanSel             - active channel (out-of-range aliases channel 0)
//        readAck/readDataIn  - DDR acknowledge and read word
//        readRequest/readAddress - DDR request and latched address
//        activeAddress/readData/dataValid - selected channel's view
//        busy, timeoutErr    - read in flight, sticky timeout flag
module ddr_probe_controller import ddr_probe_pkg::*; #(
    parameter int                    ADDR_WIDTH     = 24,
    parameter int                    DATA_WIDTH     = 16,
    parameter int                    CHANNELS       = 4,
    parameter logic [ADDR_WIDTH-1:0] ADDR_MAX       = {ADDR_WIDTH{1'b1}},
    parameter int                    WRAP           = 1,
    parameter int                    ACCEL_WINDOW   = 1_000_000,
    parameter int                    ACCEL_STEP     = 16,
    parameter int                    TIMEOUT        = 4096,
    parameter int                    REFRESH_PERIOD = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        left,
    input  logic                        right,
    input  logic                        down,
    input  logic [cw_of(CHANNELS)-1:0]  chanSel,
    input  logic                        readAck,
    input  logic [DATA_WIDTH-1:0]       readDataIn,
    output logic                        readRequest,
    output logic [ADDR_WIDTH-1:0]       readAddress,
    output logic [ADDR_WIDTH-1:0]       activeAddress,
    output logic [DATA_WIDTH-1:0]       readData,
    output logic                        dataValid,
    output logic                        busy,
    output logic                        timeoutErr
);

    localparam int CW  = cw_of(CHANNELS);
    localparam int TOW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int RW  = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam logic [ADDR_WIDTH:0] RANGE = {1'b0, ADDR_MAX} + (ADDR_WIDTH+1)'(1);

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_addr [CHANNELS];
    logic [DATA_WIDTH-1:0] r_data [CHANNELS];
    logic [CHANNELS-1:0]   r_valid;
    logic [CW-1:0]         r_tgt, w_sel;
    logic [TOW-1:0]        r_to;
    logic [RW-1:0]         r_ref;
    logic [ADDR_WIDTH-1:0] r_rd_addr, w_new;
    logic [ADDR_WIDTH:0]   w_cur, w_sum, w_step;
    logic                  r_terr, w_event, w_up_dir, w_launch, w_ref_exp, w_to_exp;

    rotary_step_gen #(
        .CHANNELS    (CHANNELS),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .ACCEL_WINDOW(ACCEL_WINDOW),
        .ACCEL_STEP  (ACCEL_STEP)
    ) u_step (
        .clk    (clk),
        .rst    (rst),
        .i_left (left),
        .i_right(right),
        .i_chan (w_sel),
        .o_event(w_event),
        .o_up   (w_up_dir),
        .o_step (w_step)
    );

    assign w_sel = ({1'b0, chanSel} < (CW+1)'(CHANNELS)) ? chanSel : '0;

    // One extra bit catches overflow/underflow before wrapping modulo ADDR_MAX+1 or clamping
    assign w_cur = {1'b0, r_addr[w_sel]};
    assign w_sum = w_cur + w_step;
    assign w_new = w_up_dir
        ? ((w_sum > {1'b0, ADDR_MAX}) ? ((WRAP != 0) ? ADDR_WIDTH'(w_sum - RANGE) : ADDR_MAX) : ADDR_WIDTH'(w_sum))
        : ((w_cur < w_step) ? ((WRAP != 0) ? ADDR_WIDTH'(w_cur + RANGE - w_step) : '0) : ADDR_WIDTH'(w_cur - w_step));

    assign w_ref_exp = (REFRESH_PERIOD != 0) && (r_ref == RW'(REFRESH_PERIOD - 1));
    assign w_launch  = (r_state == IDLE) && (down || w_ref_exp);
    assign w_to_exp  = (r_to == TOW'(TIMEOUT));

    always_ff @(posedge clk) begin
        r_state <= rst ? IDLE : w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE) ? (w_launch ? REQ : IDLE) : ((readAck || w_to_exp) ? IDLE : REQ);
    end

    always_comb begin
        readRequest = (r_state == REQ);
        busy        = (r_state == REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
            r_valid   <= '0;
            r_tgt     <= '0;
            r_rd_addr <= '0;
            r_to      <= '0;
            r_ref     <= '0;
            r_terr    <= 1'b0;
        end else begin
            if (w_event) r_addr[w_sel] <= w_new;
            // Ack beats a same-cycle timeout; the refresh counter holds at 0 while a read is in flight
            if (w_launch) begin
                r_rd_addr <= r_addr[w_sel];
                r_tgt     <= w_sel;
                r_to      <= '0;
                r_ref     <= '0;
            end else if (r_state == IDLE) begin
                r_ref <= r_ref + RW'(1);
            end else if (readAck) begin
                r_data[r_tgt]  <= readDataIn;
                r_valid[r_tgt] <= 1'b1;
                r_terr         <= 1'b0;
            end else if (w_to_exp) begin
                r_terr <= 1'b1;
            end else begin
                r_to <= r_to + TOW'(1);
            end
        end
    end

    assign readAddress   = r_rd_addr;
    assign activeAddress = r_addr[w_sel];
    assign readData      = r_data[w_sel];
    assign dataValid     = r_valid[w_sel];
    assign timeoutErr    = r_terr;

endmodule

// File: tb/tb_ddr_probe_controller.sv
// tb_ddr_probe_controller: directed self-checking bench; instance A wraps with manual reads, instance B saturates with refresh.
module tb_ddr_probe_controller;

    logic        clk, rst;
    logic        left, right, down, readAck;
    logic [1:0]  chanSel;
    logic [15:0] readDataIn;
    logic        readRequest, dataValid, busy, timeoutErr;
    logic [23:0] readAddress, activeAddress;
    logic [15:0] readData;

    logic        left_b, right_b, down_b, readAck_b;
    logic [1:0]  chanSel_b;
    logic [15:0] readDataIn_b;
    logic        readRequest_b, dataValid_b, busy_b, timeoutErr_b;
    logic [7:0]  readAddress_b, activeAddress_b;
    logic [15:0] readData_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt;

    ddr_probe_controller #(
        .ADDR_WIDTH(24), .DATA_WIDTH(16), .CHANNELS(4), .WRAP(1),
        .ACCEL_WINDOW(50), .ACCEL_STEP(16), .TIMEOUT(20), .REFRESH_PERIOD(0)
    ) u_a (
        .clk(clk), .rst(rst), .left(left), .right(right), .down(down),
        .chanSel(chanSel), .readAck(readAck), .readDataIn(readDataIn),
        .readRequest(readRequest), .readAddress(readAddress), .activeAddress(activeAddress),
        .readData(readData), .dataValid(dataValid), .busy(busy), .timeoutErr(timeoutErr)
    );

    ddr_probe_controller #(
        .ADDR_WIDTH(8), .DATA_WIDTH(16), .CHANNELS(3), .ADDR_MAX(8'd20), .WRAP(0),
        .ACCEL_WINDOW(50), .ACCEL_STEP(16), .TIMEOUT(20), .REFRESH_PERIOD(100)
    ) u_b (
        .clk(clk), .rst(rst), .left(left_b), .right(right_b), .down(down_b),
        .chanSel(chanSel_b), .readAck(readAck_b), .readDataIn(readDataIn_b),
        .readRequest(readRequest_b), .readAddress(readAddress_b), .activeAddress(activeAddress_b),
        .readData(readData_b), .dataValid(dataValid_b), .busy(busy_b), .timeoutErr(timeoutErr_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go_right();  right = 1'b1;   tick(); right = 1'b0;   endtask
    task automatic go_left();   left = 1'b1;    tick(); left = 1'b0;    endtask
    task automatic go_down();   down = 1'b1;    tick(); down = 1'b0;    endtask
    task automatic b_right();   right_b = 1'b1; tick(); right_b = 1'b0; endtask
    task automatic b_left();    left_b = 1'b1;  tick(); left_b = 1'b0;  endtask
    task automatic sel(input logic [1:0] v);   chanSel = v;   #1; endtask
    task automatic sel_b(input logic [1:0] v); chanSel_b = v; #1; endtask

    initial begin
        clk = 0; rst = 1;
        left = 0; right = 0; down = 0; readAck = 0; chanSel = 0; readDataIn = 0;
        left_b = 0; right_b = 0; down_b = 0; readAck_b = 0; chanSel_b = 0; readDataIn_b = 0;
        tick(); tick();
        rst = 0;
        chk("rst_active", activeAddress, 0);
        chk("rst_req", readRequest, 0);
        chk("rst_busy", busy, 0);
        chk("rst_terr", timeoutErr, 0);
        chk("rst_valid", dataValid, 0);
        chk("rst_data", readData, 0);
        chk("rst_raddr", readAddress, 0);

        sel(0);
        go_right(); idle(100); go_right(); idle(100); go_right();
        chk("ch0_slow_up", activeAddress, 3);
        idle(100); go_left();
        chk("ch0_slow_down", activeAddress, 2);

        sel(1);
        go_right();
        chk("ch1_first", activeAddress, 1);
        idle(9); go_right();
        chk("ch1_accel", activeAddress, 17);
        idle(9); go_left();
        chk("ch1_dir_change", activeAddress, 16);
        left = 1; right = 1; tick(); left = 0; right = 0;
        chk("ch1_both", activeAddress, 16);
        sel(0);
        chk("ch0_untouched", activeAddress, 2);

        sel(3);
        go_left();
        chk("wrap_down", activeAddress, 24'hFFFFFF);
        go_right();
        chk("wrap_up", activeAddress, 0);

        sel(2);
        go_right();
        repeat (18) begin idle(9); go_right(); end
        idle(60); go_right(); idle(60); go_right();
        chk("ch2_setup", activeAddress, 24'h000123);
        go_down();
        chk("rd_req", readRequest, 1);
        chk("rd_busy", busy, 1);
        chk("rd_addr", readAddress, 24'h000123);
        sel(0);
        go_right();
        chk("rd_step_ch0", activeAddress, 3);
        chk("rd_addr_hold", readAddress, 24'h000123);
        idle(3);
        readAck = 1; readDataIn = 16'hBEEF; tick(); readAck = 0;
        chk("ack_busy", busy, 0);
        chk("ack_req", readRequest, 0);
        chk("ack_ch0_valid", dataValid, 0);
        sel(2);
        chk("ack_ch2_data", readData, 16'hBEEF);
        chk("ack_ch2_valid", dataValid, 1);

        sel(1);
        go_down();
        chk("to_req", readRequest, 1);
        go_down();
        idle(19);
        chk("to_last_req", readRequest, 1);
        chk("to_no_err_yet", timeoutErr, 0);
        tick();
        chk("to_req_low", readRequest, 0);
        chk("to_err", timeoutErr, 1);
        tick();
        chk("to_not_queued", busy, 0);
        chk("to_valid", dataValid, 0);
        chk("to_data", readData, 0);

        go_down();
        readAck = 1; readDataIn = 16'h1234; tick(); readAck = 0;
        chk("clr_busy", busy, 0);
        chk("clr_terr", timeoutErr, 0);
        chk("clr_data", readData, 16'h1234);
        chk("clr_valid", dataValid, 1);

        readAck = 1; readDataIn = 16'hDEAD; tick(); readAck = 0;
        chk("stray_ack", readData, 16'h1234);

        go_down();
        chk("mid_busy", busy, 1);
        rst = 1; tick(); rst = 0;
        chk("mid_rst_req", readRequest, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_raddr", readAddress, 0);
        chk("mid_rst_active", activeAddress, 0);
        chk("mid_rst_data", readData, 0);
        chk("mid_rst_valid", dataValid, 0);
        chk("mid_rst_terr", timeoutErr, 0);
        chk("mid_rst_b_busy", busy_b, 0);
        readAck = 1; readDataIn = 16'h5555; tick(); readAck = 0;
        chk("late_ack_data", readData, 0);
        chk("late_ack_valid", dataValid, 0);

        sel_b(3);
        b_left();
        chk("sat_low", activeAddress_b, 0);
        b_right();
        chk("sat_first", activeAddress_b, 1);
        idle(9); b_right();
        chk("sat_accel", activeAddress_b, 17);
        idle(9); b_right();
        chk("sat_clamp", activeAddress_b, 20);
        b_right();
        chk("sat_hold", activeAddress_b, 20);
        sel_b(0);
        chk("sel_alias", activeAddress_b, 20);

        cnt = 0;
        while (!readRequest_b && cnt < 200) begin tick(); cnt++; end
        chk("ref_first", readRequest_b, 1);
        chk("ref_addr", readAddress_b, 20);
        readAck_b = 1; readDataIn_b = 16'hA5A5; tick(); readAck_b = 0;
        chk("ref_busy", busy_b, 0);
        chk("ref_data", readData_b, 16'hA5A5);
        chk("ref_valid", dataValid_b, 1);
        chk("ref_terr", timeoutErr_b, 0);
        cnt = 0;
        while (!readRequest_b && cnt < 300) begin tick(); cnt++; end
        chk("ref_period", cnt, 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
